countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 86 ++++++++
 tb/tb_countdown_timer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Seconds countdown timer with pause/resume, a one-second prescaler,
// per-second tick pulses, a warning band and an expiry pulse/level.
module countdown_timer #(
  parameter int TICKS_PER_SEC = 12000000,
  parameter int WARN_SECS     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [9:0] load_value,
  input  logic       start,
  input  logic       pause,
  output logic [9:0] remaining,
  output logic       running,
  output logic       tick,
  output logic       expire_pulse,
  output logic       expired,
  output logic       warn
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  localparam logic [26:0] LAST_COUNT = 27'(TICKS_PER_SEC - 1);

  state_t      state;
  logic [26:0] prescaler;
  logic [31:0] remaining_wide;

  // Priority: reset > load > pause > start. The prescaler only advances in RUN,
  // so a resume continues the partially elapsed second.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      prescaler    <= '0;
      remaining    <= '0;
      tick         <= 1'b0;
      expire_pulse <= 1'b0;
    end else begin
      tick         <= 1'b0;
      expire_pulse <= 1'b0;
      if (load) begin
        remaining <= load_value;
        prescaler <= '0;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE, PAUSE: begin
            if (start && !pause) begin
              if (remaining != '0) begin
                state <= RUN;
              end else begin
                state        <= EXPIRED;
                expire_pulse <= 1'b1;
              end
            end
          end
          RUN: begin
            if (pause) begin
              state <= PAUSE;
            end else if (prescaler == LAST_COUNT) begin
              prescaler <= '0;
              if (remaining != '0) begin
                remaining <= remaining - 10'd1;
                tick      <= 1'b1;
                if (remaining == 10'd1) begin
                  state        <= EXPIRED;
                  expire_pulse <= 1'b1;
                end
              end
            end else begin
              prescaler <= prescaler + 27'd1;
            end
          end
          EXPIRED: state <= EXPIRED;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign running        = (state == RUN);
  assign expired        = (state == EXPIRED);
  assign remaining_wide = {22'd0, remaining};
  assign warn           = running && (remaining != '0) && (remaining_wide <= 32'(WARN_SECS));

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer (TICKS_PER_SEC=4, WARN_SECS=2):
// stimulus pushes hand-computed per-cycle expectations, a monitor compares them.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [9:0] load_value = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] remaining;
  logic       running, tick, expire_pulse, expired, warn;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string      name;
    logic [9:0] rem;
    logic [4:0] flags;  // {running, tick, expire_pulse, expired, warn}
  } expect_t;

  expect_t exp_q[$];

  countdown_timer #(.TICKS_PER_SEC(4), .WARN_SECS(2)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .remaining(remaining), .running(running),
    .tick(tick), .expire_pulse(expire_pulse), .expired(expired), .warn(warn)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per clock, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      expect_t e;
      logic [4:0] act;
      e = exp_q.pop_front();
      act = {running, tick, expire_pulse, expired, warn};
      checks++;
      if (remaining === e.rem && act === e.flags)
        passed++;
      else
        $display("[TB] FAIL %s: got remaining=%0d flags(run,tick,xp,exp,warn)=%b, want remaining=%0d flags=%b",
                 e.name, remaining, act, e.rem, e.flags);
    end
  end

  task automatic cyc(input string name, input logic rst_n, input logic ld, input logic [9:0] lv,
                     input logic st, input logic pa, input logic [9:0] er, input logic [4:0] ef);
    expect_t e;
    reset = rst_n; load = ld; load_value = lv; start = st; pause = pa;
    @(posedge clk);
    #1;
    e.name = name; e.rem = er; e.flags = ef;
    exp_q.push_back(e);
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic hold(input string name, input int n, input logic [9:0] er, input logic [4:0] ef);
    for (int i = 0; i < n; i++) cyc(name, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, er, ef);
  endtask

  task automatic holdPause(input string name, input int n, input logic [9:0] er, input logic [4:0] ef);
    for (int i = 0; i < n; i++) cyc(name, 1'b1, 1'b0, 10'd0, 1'b0, 1'b1, er, ef);
  endtask

  initial begin
    // Reset state, and reset overriding a coincident load
    cyc("reset0", 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 5'b00000);
    cyc("reset_vs_load", 1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 5'b00000);
    hold("post_reset", 1, 10'd0, 5'b00000);

    // Load 3, start: ticks at RUN cycles 4, 8, 12
    cyc("load3", 1'b1, 1'b1, 10'd3, 1'b0, 1'b0, 10'd3, 5'b00000);
    cyc("start3", 1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 10'd3, 5'b10000);
    hold("run3_pre", 3, 10'd3, 5'b10000);
    hold("tick1_rem2", 1, 10'd2, 5'b11001);
    hold("run_rem2", 3, 10'd2, 5'b10001);
    hold("tick2_rem1", 1, 10'd1, 5'b11001);
    hold("run_rem1", 3, 10'd1, 5'b10001);
    hold("tick3_expire", 1, 10'd0, 5'b01110);
    hold("expired_level", 1, 10'd0, 5'b00010);
    cyc("start_in_expired", 1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 10'd0, 5'b00010);

    // Load 0 then start: immediate expiry, no tick
    cyc("load0", 1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 10'd0, 5'b00000);
    cyc("start_zero", 1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 10'd0, 5'b00110);
    hold("zero_expired", 1, 10'd0, 5'b00010);

    // Load 5, start, 6 cycles, pause 10 cycles, resume
    cyc("load5", 1'b1, 1'b1, 10'd5, 1'b0, 1'b0, 10'd5, 5'b00000);
    cyc("start5", 1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 10'd5, 5'b10000);
    hold("run5", 3, 10'd5, 5'b10000);
    hold("tick_rem4", 1, 10'd4, 5'b11000);
    hold("run4", 2, 10'd4, 5'b10000);
    holdPause("paused4", 10, 10'd4, 5'b00000);
    cyc("resume4", 1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 10'd4, 5'b10000);
    hold("resume_partial", 1, 10'd4, 5'b10000);
    hold("tick_rem3", 1, 10'd3, 5'b11000);
    hold("run3", 3, 10'd3, 5'b10000);
    hold("tick_rem2_warn", 1, 10'd2, 5'b11001);

    // load + start + pause together in RUN: load wins
    cyc("load_wins", 1'b1, 1'b1, 10'd9, 1'b1, 1'b1, 10'd9, 5'b00000);
    hold("idle9", 1, 10'd9, 5'b00000);

    // Pause on the boundary cycle: no tick, tick right after resume
    cyc("start9", 1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 10'd9, 5'b10000);
    hold("run9", 3, 10'd9, 5'b10000);
    cyc("pause_at_boundary", 1'b1, 1'b0, 10'd0, 1'b0, 1'b1, 10'd9, 5'b00000);
    cyc("resume9", 1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 10'd9, 5'b10000);
    hold("tick_rem8", 1, 10'd8, 5'b11000);

    // Reset mid-RUN with remaining=7, then start expires immediately
    cyc("load7", 1'b1, 1'b1, 10'd7, 1'b0, 1'b0, 10'd7, 5'b00000);
    cyc("start7", 1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 10'd7, 5'b10000);
    hold("run7", 2, 10'd7, 5'b10000);
    cyc("reset_mid_run", 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 5'b00000);
    hold("after_reset", 1, 10'd0, 5'b00000);
    cyc("start_after_reset", 1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 10'd0, 5'b00110);

    // Pause ignored in IDLE; remaining=1 runs in warn band then expires
    cyc("load1", 1'b1, 1'b1, 10'd1, 1'b0, 1'b0, 10'd1, 5'b00000);
    cyc("pause_idle", 1'b1, 1'b0, 10'd0, 1'b0, 1'b1, 10'd1, 5'b00000);
    cyc("start1", 1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 10'd1, 5'b10001);
    hold("run1", 3, 10'd1, 5'b10001);
    hold("tick_expire1", 1, 10'd0, 5'b01110);
    hold("expired_hold", 2, 10'd0, 5'b00010);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
